saradc_sar_logic: RTL
=====================

SARADC_SAR_LOGIC -- requirements
Module: saradc_sar_logic

Interface
REQ-001 The block SHALL have parameter NBITS, default 8, setting the conversion resolution (2..16).
REQ-002 The block SHALL have parameter SAMPLE_CYC, default 2, setting the number of sampling cycles (>=1).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 8, setting the maximum number of cycles to wait for a comparator decision (>=2).
REQ-004 Port CLK, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 Port RSTN, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 Port START, input, 1 bit: conversion request, level-sampled in IDLE only.
REQ-007 Port COMP_VALID, input, 1 bit: comparator decision ready, synchronous to CLK.
REQ-008 Port COMP_OUT, input, 1 bit: comparator decision; 1 means Vin >= Vdac; qualified by COMP_VALID.
REQ-009 Port SAMPLE, output, 1 bit: sampling-switch enable.
REQ-010 Port COMP_EN, output, 1 bit: one-cycle comparator trigger.
REQ-011 Port DAC_P, output, NBITS bits: capacitor-DAC switch code.
REQ-012 Port DATA, output, NBITS bits: last completed conversion result.
REQ-013 Port BUSY, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-014 Port DONE, output, 1 bit: one-cycle pulse when DATA updates.
REQ-015 Port TIMEOUT, output, 1 bit: sticky flag; set if any bit timed out in the current or last conversion.

Function
REQ-016 The FSM SHALL have the states IDLE, SAMPLE, TRIAL, WAIT and DONE, with all outputs registered.
REQ-017 In IDLE, START=1 SHALL cause the following transitions on the next edge: move to SAMPLE, clear TIMEOUT, clear DAC_P to 0, load the sample counter with SAMPLE_CYC-1, and load the bit index with NBITS-1.
REQ-018 SAMPLE SHALL stay asserted for exactly SAMPLE_CYC cycles, after which the FSM SHALL move to TRIAL.
REQ-019 In TRIAL, the FSM SHALL set DAC_P[idx]=1, assert COMP_EN for that single cycle, load the timeout counter, and move to WAIT.
REQ-020 In WAIT, COMP_VALID=1 SHALL set DAC_P[idx] to COMP_OUT.
REQ-021 In WAIT, if the timeout counter expires with no COMP_VALID, the FSM SHALL set DAC_P[idx]=0 and set TIMEOUT.
REQ-022 On a COMP_VALID and timeout expiry in the same cycle, COMP_VALID SHALL take precedence.
REQ-023 After a bit resolves in WAIT, the FSM SHALL go to DONE if idx==0; otherwise it SHALL decrement idx and go to TRIAL.
REQ-024 DONE SHALL load DATA with DAC_P, pulse DONE=1 for one cycle, and return to IDLE; DAC_P SHALL hold its value until the next START.
REQ-025 COMP_VALID outside WAIT SHALL be ignored.
REQ-026 START outside IDLE SHALL be ignored, including START held high during DONE.
REQ-027 START held high continuously SHALL produce back-to-back conversions with exactly one IDLE cycle between them.
REQ-028 Latency from START sampled in IDLE to the DONE pulse SHALL be SAMPLE_CYC + 2*NBITS + 1 cycles when each COMP_VALID arrives in the first WAIT cycle.
REQ-029 Each bit SHALL take at most 1 + TIMEOUT_CYC cycles.

Reset
REQ-030 RSTN=0 SHALL immediately force the FSM to IDLE and drive SAMPLE=0, COMP_EN=0, BUSY=0, DONE=0, TIMEOUT=0, DAC_P=0, DATA=0, and all counters to 0.
REQ-031 Reset asserted mid-conversion SHALL abort the conversion without producing a DONE pulse and SHALL leave DATA=0.
REQ-032 The first START SHALL be accepted in the first cycle after RSTN deasserts.

Structure
REQ-033 The FSM state enumeration and default parameter constants SHALL reside in a shared package, saradc_pkg.
REQ-034 The timeout counter SHALL be a single sub-module, saradc_timeout_cnt, with load, enable and expired ports; all other logic SHALL be in one module.

Verification
REQ-035 Test 1: NBITS=8, SAMPLE_CYC=2, comparator model with Vin code 0xA5 and valid one cycle after COMP_EN; START at cycle 0 -> SAMPLE high in cycles 1-2, DONE in cycle 19, DATA=0xA5, TIMEOUT=0.
REQ-036 Test 2: codes 0x00 and 0xFF -> DATA=0x00 and DATA=0xFF respectively, with DAC_P equal to DATA after DONE.
REQ-037 Test 3: comparator silent for bit 5 only, Vin=0xFF -> that bit waits 8 cycles, DATA=0xDF, TIMEOUT=1, DONE delayed 7 cycles relative to Test 1.
REQ-038 Test 4: RSTN pulsed low during the WAIT of bit 3 -> all outputs 0 immediately, no DONE pulse, next START converts correctly.
REQ-039 Test 5: START held high for 3 conversions, spurious COMP_VALID in SAMPLE/TRIAL, and START pulses while BUSY -> 3 DONE pulses spaced 20 cycles apart, results unaffected.

Source files
------------

// File: rtl/saradc_pkg.sv
// Shared types and default sizing for the SAR ADC successive-approximation controller.
package saradc_pkg;

  localparam int DEF_NBITS       = 8;
  localparam int DEF_SAMPLE_CYC  = 2;
  localparam int DEF_TIMEOUT_CYC = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_TRIAL,
    ST_WAIT,
    ST_DONE
  } sar_state_e;

endpackage

// File: rtl/saradc_sar_logic_if.sv
// Control/data bundle between the SAR controller (master) and the analog front end / system (slave).
interface saradc_sar_logic_if #(
  parameter int NBITS = saradc_pkg::DEF_NBITS
);

  logic             start;
  logic             comp_valid;
  logic             comp_out;
  logic             sample;
  logic             comp_en;
  logic [NBITS-1:0] dac_p;
  logic [NBITS-1:0] data;
  logic             busy;
  logic             done;
  logic             timeout;

  modport master (
    input  start, comp_valid, comp_out,
    output sample, comp_en, dac_p, data, busy, done, timeout
  );

  modport slave (
    output start, comp_valid, comp_out,
    input  sample, comp_en, dac_p, data, busy, done, timeout
  );

endinterface

// File: rtl/saradc_timeout_cnt.sv
// Comparator-decision watchdog: down-counter loaded with TIMEOUT_CYC-1, expired at terminal count.
module saradc_timeout_cnt
  import saradc_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rstn,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= CW'(TIMEOUT_CYC - 1);
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/saradc_sar_logic.sv
// Successive-approximation controller: sample, then resolve one DAC bit per TRIAL/WAIT pair, MSB first.
//
// state  | meaning
// IDLE   | waiting for start; dac_p/data/timeout hold last conversion
// SAMPLE | sampling switch closed for SAMPLE_CYC cycles
// TRIAL  | trial bit set, comparator triggered, watchdog loaded
// WAIT   | waiting for comp_valid or watchdog expiry to resolve bit idx
// DONE   | result published with a one-cycle done pulse
module saradc_sar_logic
  import saradc_pkg::*;
#(
  parameter int NBITS       = DEF_NBITS,
  parameter int SAMPLE_CYC  = DEF_SAMPLE_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input logic                clk,
  input logic                rstn,
  saradc_sar_logic_if.master bus
);

  localparam int IW = $clog2(NBITS);
  localparam int SW = $clog2(SAMPLE_CYC + 1);

  sar_state_e       state_q, state_d;
  logic [NBITS-1:0] dac_p_q, dac_p_d;
  logic [NBITS-1:0] data_q, data_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SW-1:0]    samp_cnt_q, samp_cnt_d;
  logic             sample_q, sample_d;
  logic             comp_en_q, comp_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             tmo_load, tmo_en, tmo_expired;

  saradc_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_tmo (
    .clk     (clk),
    .rstn    (rstn),
    .load    (tmo_load),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      dac_p_q    <= '0;
      data_q     <= '0;
      idx_q      <= '0;
      samp_cnt_q <= '0;
      sample_q   <= 1'b0;
      comp_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dac_p_q    <= dac_p_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      samp_cnt_q <= samp_cnt_d;
      sample_q   <= sample_d;
      comp_en_q  <= comp_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // Outputs are computed for the next state so every port comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    dac_p_d    = dac_p_q;
    data_d     = data_q;
    idx_d      = idx_q;
    samp_cnt_d = samp_cnt_q;
    sample_d   = 1'b0;
    comp_en_d  = 1'b0;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    tmo_load   = 1'b0;
    tmo_en     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d    = ST_SAMPLE;
          sample_d   = 1'b1;
          timeout_d  = 1'b0;
          dac_p_d    = '0;
          samp_cnt_d = SW'(SAMPLE_CYC - 1);
          idx_d      = IW'(NBITS - 1);
        end
      end
      ST_SAMPLE: begin
        if (samp_cnt_q == '0) begin
          state_d          = ST_TRIAL;
          dac_p_d[idx_q]   = 1'b1;
          comp_en_d        = 1'b1;
        end else begin
          samp_cnt_d = samp_cnt_q - SW'(1);
          sample_d   = 1'b1;
        end
      end
      ST_TRIAL: begin
        tmo_load = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        tmo_en = 1'b1;
        // comp_valid wins over a simultaneous expiry; a timed-out bit resolves to 0
        if (bus.comp_valid || tmo_expired) begin
          dac_p_d[idx_q] = bus.comp_valid & bus.comp_out;
          if (!bus.comp_valid) begin
            timeout_d = 1'b1;
          end
          if (idx_q == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            data_d  = dac_p_d;
          end else begin
            idx_d          = idx_q - IW'(1);
            dac_p_d[idx_d] = 1'b1;
            comp_en_d      = 1'b1;
            state_d        = ST_TRIAL;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.sample  = sample_q;
  assign bus.comp_en = comp_en_q;
  assign bus.dac_p   = dac_p_q;
  assign bus.data    = data_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.timeout = timeout_q;

endmodule
